// File: rtl/asymmetric_fifo_sc.sv
// Single-clock FIFO with independent write/read widths over a narrow-word RAM.
// Wide words are packed little-endian: the first narrow word sits in the low slice.
module asymmetric_fifo_sc #(
    parameter int unsigned WIDTHA = 8,
    parameter int unsigned WIDTHB = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [WIDTHA-1:0]      di_i,
    output logic                   full_o,
    input  logic                   re_i,
    output logic [WIDTHB-1:0]      do_o,
    output logic                   valid_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);
    localparam int unsigned MINW = (WIDTHA < WIDTHB) ? WIDTHA : WIDTHB;
    localparam int unsigned WU   = WIDTHA / MINW;
    localparam int unsigned RU   = WIDTHB / MINW;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    logic [MINW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTHB-1:0] do_q, do_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full_c, empty_c, wa_c, ra_c;
    logic [WIDTHB-1:0] rdata_c;

    // Flow-control flags depend only on the registered occupancy.
    always_comb begin
        full_c  = (CW'(DEPTH) - count_q) < CW'(WU);
        empty_c = count_q < CW'(RU);
        wa_c    = we_i & ~full_c;
        ra_c    = re_i & ~empty_c;
    end

    always_comb begin
        rdata_c = '0;
        for (int unsigned k = 0; k < RU; k++) begin
            rdata_c[k*MINW +: MINW] = mem_q[rptr_q + AW'(k)];
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        do_d    = do_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q | (we_i & full_c);
        udf_d   = udf_q | (re_i & empty_c);
        if (wa_c) begin
            wptr_d = wptr_q + AW'(WU);
        end
        if (ra_c) begin
            rptr_d  = rptr_q + AW'(RU);
            do_d    = rdata_c;
            valid_d = 1'b1;
        end
        count_d = count_q + (wa_c ? CW'(WU) : CW'(0)) - (ra_c ? CW'(RU) : CW'(0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            do_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            do_q    <= do_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk_i) begin
        if (wa_c && !rst_i) begin
            for (int unsigned k = 0; k < WU; k++) begin
                mem_q[wptr_q + AW'(k)] <= di_i[k*MINW +: MINW];
            end
        end
    end

    assign full_o      = full_c;
    assign empty_o     = empty_c;
    assign count_o     = count_q;
    assign do_o        = do_q;
    assign valid_o     = valid_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: tb/tb_asymmetric_fifo_sc.sv
// Bench for asymmetric_fifo_sc: 8->32 instance driven by a table and a byte-queue model,
// plus a 32->8 instance exercised by a short hand-written sequence.
module tb_asymmetric_fifo_sc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8 -> 32 instance
    logic        a_rst = 1'b1, a_we = 1'b0, a_re = 1'b0;
    logic [7:0]  a_di = '0;
    logic        a_full, a_valid, a_empty, a_ovf, a_udf;
    logic [31:0] a_do;
    logic [4:0]  a_count;

    // 32 -> 8 instance
    logic        b_rst = 1'b1, b_we = 1'b0, b_re = 1'b0;
    logic [31:0] b_di = '0;
    logic        b_full, b_valid, b_empty, b_ovf, b_udf;
    logic [7:0]  b_do;
    logic [4:0]  b_count;

    asymmetric_fifo_sc #(.WIDTHA(8), .WIDTHB(32), .DEPTH(16)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .we_i(a_we), .di_i(a_di), .full_o(a_full),
        .re_i(a_re), .do_o(a_do), .valid_o(a_valid), .empty_o(a_empty),
        .count_o(a_count), .overflow_o(a_ovf), .underflow_o(a_udf)
    );

    asymmetric_fifo_sc #(.WIDTHA(32), .WIDTHB(8), .DEPTH(16)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .we_i(b_we), .di_i(b_di), .full_o(b_full),
        .re_i(b_re), .do_o(b_do), .valid_o(b_valid), .empty_o(b_empty),
        .count_o(b_count), .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state for dut_a: byte queue plus sticky flags and expected read words.
    logic [7:0]  mq[$];
    logic [31:0] sb[$];
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    logic [31:0] last_do = '0;

    typedef struct {
        logic        we;
        logic [7:0]  di;
        logic        re;
        logic [4:0]  cnt;
        logic        emp;
        logic        vld;
        logic [31:0] dout;
        logic        udf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_a(input logic we, input logic re);
        a_rst = 1'b1;
        a_we  = we;
        a_re  = re;
        a_di  = 8'hFF;
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_we  = 1'b0;
        a_re  = 1'b0;
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_do",    a_do,         32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_udf",   32'(a_udf),   32'd0);
        mq.delete();
        sb.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        last_do = '0;
    endtask

    // One model-checked cycle on dut_a.
    task automatic cyc_a(input logic we, input logic [7:0] di, input logic re);
        logic        m_full, m_empty, wa, ra;
        logic [31:0] w, exp;
        m_full  = (16 - mq.size()) < 1;
        m_empty = mq.size() < 4;
        chk("a_count", 32'(a_count), 32'(mq.size()));
        chk("a_full",  32'(a_full),  32'(m_full));
        chk("a_empty", 32'(a_empty), 32'(m_empty));
        chk("a_ovf",   32'(a_ovf),   32'(m_ovf));
        chk("a_udf",   32'(a_udf),   32'(m_udf));
        wa = we && !m_full;
        ra = re && !m_empty;
        if (we && m_full)  m_ovf = 1'b1;
        if (re && m_empty) m_udf = 1'b1;
        if (ra) begin
            w = '0;
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = mq.pop_front();
            sb.push_back(w);
        end
        if (wa) mq.push_back(di);
        a_we = we;
        a_di = di;
        a_re = re;
        @(posedge clk); #1;
        a_we = 1'b0;
        a_re = 1'b0;
        chk("a_valid", 32'(a_valid), 32'(ra));
        if (a_valid) begin
            chk("a_sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("a_do", a_do, exp);
                last_do = exp;
            end
        end else begin
            chk("a_do_hold", a_do, last_do);
            if (ra) exp = sb.pop_front();
        end
    endtask

    task automatic step_b(input logic we, input logic [31:0] di, input logic re);
        b_we = we;
        b_di = di;
        b_re = re;
        @(posedge clk); #1;
        b_we = 1'b0;
        b_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b[4];
        int fill;

        tbl[0]  = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 5'd4, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 32'h44332211, 1'b0};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 5'd1, 1'b1, 1'b0, 32'h44332211, 1'b0};
        tbl[6]  = '{1'b1, 8'h66, 1'b0, 5'd2, 1'b1, 1'b0, 32'h44332211, 1'b0};
        tbl[7]  = '{1'b1, 8'h77, 1'b0, 5'd3, 1'b1, 1'b0, 32'h44332211, 1'b0};
        tbl[8]  = '{1'b1, 8'h88, 1'b0, 5'd4, 1'b0, 1'b0, 32'h44332211, 1'b0};
        tbl[9]  = '{1'b1, 8'hAA, 1'b1, 5'd1, 1'b1, 1'b1, 32'h88776655, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 1'b0, 32'h88776655, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 32'h88776655, 1'b1};

        @(posedge clk); #1;
        reset_a(1'b0, 1'b0);

        // Basic packing, same-cycle write+read, and underflow on a partial word.
        for (int i = 0; i < 12; i++) begin
            a_we = tbl[i].we;
            a_di = tbl[i].di;
            a_re = tbl[i].re;
            @(posedge clk); #1;
            a_we = 1'b0;
            a_re = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(a_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(tbl[i].emp));
            chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d_do", i),    a_do,         tbl[i].dout);
            chk($sformatf("vec%0d_udf", i),   32'(a_udf),   32'(tbl[i].udf));
        end

        // Fill to full, overflow on the 17th write, then drain.
        reset_a(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 8'(i), 1'b0);
        cyc_a(1'b1, 8'h99, 1'b0);
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 8'h00, 1'b1);

        // Three fill/drain rounds through the wrap point.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) cyc_a(1'b1, 8'(r*16 + i + 8'h40), 1'b0);
            for (int i = 0; i < 4; i++) cyc_a(1'b0, 8'h00, 1'b1);
        end

        // Random traffic leaves pointers at arbitrary offsets.
        for (int i = 0; i < 300; i++)
            cyc_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

        // Reset with count=12, overflow set and a read requested in the reset cycle.
        while (mq.size() >= 4) cyc_a(1'b0, 8'h00, 1'b1);
        fill = 12 - mq.size();
        for (int i = 0; i < fill; i++) cyc_a(1'b1, 8'(8'hE0 + i), 1'b0);
        cyc_a(1'b1, 8'h99, 1'b1);
        while (mq.size() < 16) cyc_a(1'b1, 8'h5A, 1'b0);
        cyc_a(1'b1, 8'h99, 1'b0);
        while (mq.size() > 12) cyc_a(1'b0, 8'h00, 1'b1);
        while (mq.size() < 12) cyc_a(1'b1, 8'h3C, 1'b0);
        chk("pre_rst_count", 32'(a_count), 32'd12);
        reset_a(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 8'(8'hC0 + i), 1'b0);
        cyc_a(1'b0, 8'h00, 1'b1);
        chk("post_rst_word", a_do, 32'hC3C2C1C0);
        chk("a_sb_drained", 32'(sb.size()), 32'd0);

        // Wide-to-narrow instance.
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        chk("b_rst_count", 32'(b_count), 32'd0);
        chk("b_rst_empty", 32'(b_empty), 32'd1);
        chk("b_rst_full",  32'(b_full),  32'd0);
        step_b(1'b1, 32'hA1B2C3D4, 1'b0);
        chk("b_count4", 32'(b_count), 32'd4);
        chk("b_empty4", 32'(b_empty), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step_b(1'b0, 32'h0, 1'b1);
            chk($sformatf("b_valid%0d", i), 32'(b_valid), 32'd1);
            chk($sformatf("b_do%0d", i),    32'(b_do),    32'(exp_b[i]));
            chk($sformatf("b_count_rd%0d", i), 32'(b_count), 32'(3 - i));
        end
        chk("b_empty0", 32'(b_empty), 32'd1);
        step_b(1'b0, 32'h0, 1'b1);
        chk("b_udf",        32'(b_udf),   32'd1);
        chk("b_valid_rej",  32'(b_valid), 32'd0);
        chk("b_do_hold",    32'(b_do),    32'hA1);
        for (int i = 0; i < 4; i++) step_b(1'b1, 32'h01020304 * (i + 1), 1'b0);
        chk("b_full16",  32'(b_full),  32'd1);
        chk("b_empty16", 32'(b_empty), 32'd0);
        chk("b_count16", 32'(b_count), 32'd16);
        chk("b_ovf0",    32'(b_ovf),   32'd0);
        step_b(1'b1, 32'hDEADBEEF, 1'b0);
        chk("b_ovf1",      32'(b_ovf),   32'd1);
        chk("b_count_ovf", 32'(b_count), 32'd16);
        step_b(1'b0, 32'h0, 1'b1);
        chk("b_first_after_fill", 32'(b_do), 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
